// File: rtl/aes_pkg.sv
// Shared AES constants: forward/inverse S-box tables, byte type and FIPS-197 test bytes.
// Tables are packed [0:255] so that index b selects the entry for input byte b.
package aes_pkg;

  typedef logic [7:0] byte_t;

  localparam logic [0:255][7:0] SBOX_FWD = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [0:255][7:0] SBOX_INV = {
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // FIPS-197 reference pairs: S(TEST_IN[i]) = TEST_OUT[i]
  localparam logic [0:3][7:0] TEST_IN  = {8'h00, 8'h01, 8'h53, 8'hff};
  localparam logic [0:3][7:0] TEST_OUT = {8'h63, 8'h7c, 8'hed, 8'h16};

endpackage

// File: rtl/sbox_lane.sv
// One byte lane of SubBytes: combinational forward or inverse S-box lookup.
module sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] din,
  input  logic       inv,
  output logic [7:0] dout
);

  // Table select on direction
  always_comb begin
    if (inv) begin
      dout = SBOX_INV[din];
    end else begin
      dout = SBOX_FWD[din];
    end
  end

endmodule

// File: rtl/sub_bytes_pipe.sv
// Two-stage SubBytes/InvSubBytes pipeline with valid/ready backpressure and flush.
// S1 holds the raw beat, S2 holds the substituted beat; the lookup sits between them.
module sub_bytes_pipe
  import aes_pkg::*;
#(
  parameter int LANES = 16,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_inv,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic [1:0]         occupancy
);

  logic               s1_valid_r;
  logic [8*LANES-1:0] s1_data_r;
  logic               s1_inv_r;
  logic [TAG_W-1:0]   s1_tag_r;
  logic               s2_valid_r;
  logic [8*LANES-1:0] s2_data_r;
  logic [TAG_W-1:0]   s2_tag_r;
  logic [8*LANES-1:0] sub_s;
  logic               s1_adv_s;
  logic               s2_adv_s;

  genvar k;
  generate
    for (k = 0; k < LANES; k++) begin : g_lane
      sbox_lane u_lane (
        .din  (s1_data_r[8*k +: 8]),
        .inv  (s1_inv_r),
        .dout (sub_s[8*k +: 8])
      );
    end
  endgenerate

  assign s2_adv_s  = !s2_valid_r || out_ready;
  assign s1_adv_s  = !s1_valid_r || s2_adv_s;
  assign in_ready  = s1_adv_s;
  assign out_valid = s2_valid_r;
  assign out_data  = s2_data_r;
  assign out_tag   = s2_tag_r;
  assign occupancy = {1'b0, s1_valid_r} + {1'b0, s2_valid_r};

  // Stage valid bits; flush wins over any transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
    end else if (flush) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
    end else begin
      if (s1_adv_s) begin
        s1_valid_r <= in_valid;
      end
      if (s2_adv_s) begin
        s2_valid_r <= s1_valid_r;
      end
    end
  end

  // Stage payloads; untouched by flush, held while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data_r <= '0;
      s1_inv_r  <= 1'b0;
      s1_tag_r  <= '0;
      s2_data_r <= '0;
      s2_tag_r  <= '0;
    end else begin
      if (s1_adv_s && in_valid) begin
        s1_data_r <= in_data;
        s1_inv_r  <= in_inv;
        s1_tag_r  <= in_tag;
      end
      if (s2_adv_s && s1_valid_r) begin
        s2_data_r <= sub_s;
        s2_tag_r  <= s1_tag_r;
      end
    end
  end

endmodule

// File: tb/tb_sub_bytes_pipe.sv
// Scoreboard bench for sub_bytes_pipe (LANES=16): directed FIPS-197 vectors,
// round trip over all 256 bytes, backpressure, flush, reset and a random soak.
module tb_sub_bytes_pipe;

  localparam int L  = 16;
  localparam int TW = 4;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   tag;
    bit           chk;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         in_inv = 1'b0;
  logic [3:0]   in_tag = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic [3:0]   out_tag;
  logic [1:0]   occupancy;

  exp_t         sbq[$];
  logic [127:0] cap[$];
  int           n_chk = 0;
  int           n_pass = 0;
  bit           s_ready, s_ovalid, s_acc;
  logic [1:0]   s_occ;
  bit           hold_v = 1'b0;
  logic [127:0] held_data;
  logic [3:0]   held_tag;

  // Hand-written FIPS-197 pairs: fwd_a -> fwd_b under S, fwd_b -> fwd_a under InvS
  logic [7:0] fwd_a [4] = '{8'h00, 8'h01, 8'h53, 8'hff};
  logic [7:0] fwd_b [4] = '{8'h63, 8'h7c, 8'hed, 8'h16};

  sub_bytes_pipe #(.LANES(L), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_inv(in_inv), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input bit ok, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic exp_t mk(input logic [127:0] d, input logic [3:0] t, input bit c);
    exp_t e;
    e.data = d; e.tag = t; e.chk = c;
    return e;
  endfunction

  // One cycle: drive after posedge, sample/bookkeep at negedge
  task automatic step(input bit v, input logic [127:0] d, input bit inv, input logic [3:0] tg,
                      input bit ordy, input bit fl, input exp_t e);
    in_valid = v; in_data = d; in_inv = inv; in_tag = tg; out_ready = ordy; flush = fl;
    @(negedge clk);
    s_ready = in_ready; s_ovalid = out_valid; s_occ = occupancy;
    s_acc = v && in_ready && !fl;
    if (fl) sbq.delete();
    if (s_acc) sbq.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, '0, 1'b0, 4'h0, ordy, 1'b0, mk('0, 4'h0, 1'b0));
  endtask

  task automatic send(input logic [127:0] d, input bit inv, input logic [3:0] tg, input bit ordy,
                      input exp_t e);
    int tries = 0;
    do begin
      step(1'b1, d, inv, tg, ordy, 1'b0, e);
      tries++;
    end while (!s_acc && tries < 50);
    if (!s_acc) chk("send_timeout", 1'b0, 128'(tries), 128'd50);
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 40) begin idle(1'b1); n++; end
    chk("drain_empty", sbq.size() == 0, 128'(sbq.size()), 128'd0);
  endtask

  // Random beat made of known pairs, with its expected substitution
  task automatic gen(input bit inv, output logic [127:0] d, output logic [127:0] e);
    for (int k = 0; k < L; k++) begin
      int j = $urandom_range(0, 3);
      d[8*k +: 8] = inv ? fwd_b[j] : fwd_a[j];
      e[8*k +: 8] = inv ? fwd_a[j] : fwd_b[j];
    end
  endtask

  // Monitor: pop and compare on every accepted output beat
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready && !flush) begin
      if (sbq.size() == 0) begin
        chk("unexpected_out", 1'b0, out_data, '0);
      end else begin
        e = sbq.pop_front();
        if (e.chk) chk("out_data", out_data == e.data, out_data, e.data);
        else cap.push_back(out_data);
        chk("out_tag", out_tag == e.tag, 128'(out_tag), 128'(e.tag));
      end
    end
  end

  // Stall monitor: output must hold while out_valid && !out_ready
  always @(negedge clk) begin
    if (rst) begin
      hold_v <= 1'b0;
    end else begin
      if (hold_v && !flush) begin
        chk("stall_valid", out_valid, 128'(out_valid), 128'd1);
        chk("stall_data", out_data == held_data && out_tag == held_tag, out_data, held_data);
      end
      hold_v    <= out_valid && !out_ready && !flush;
      held_data <= out_data;
      held_tag  <= out_tag;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] d, e;
    bit inv, v, fl, ordy;

    // Reset state
    #12;
    chk("rst_in_ready", in_ready == 1'b1, 128'(in_ready), 128'd1);
    chk("rst_out_valid", out_valid == 1'b0, 128'(out_valid), 128'd0);
    chk("rst_occ", occupancy == 2'd0, 128'(occupancy), 128'd0);
    chk("rst_out_data", out_data == '0, out_data, '0);
    @(posedge clk); #1; rst = 1'b0;

    // Forward FIPS vector in low 4 lanes; latency: valid only after the second edge
    step(1'b1, {96'h0, 32'h53ff0100}, 1'b0, 4'h5, 1'b1, 1'b0,
         mk({{12{8'h63}}, 32'hed167c63}, 4'h5, 1'b1));
    chk("fwd_accept", s_acc, 128'(s_acc), 128'd1);
    idle(1'b1);
    chk("lat_not_early", s_ovalid == 1'b0, 128'(s_ovalid), 128'd0);
    idle(1'b1);
    chk("lat_edge2", s_ovalid == 1'b1, 128'(s_ovalid), 128'd1);
    // Inverse FIPS vector
    send({{12{8'h16}}, 32'h6316ed7c}, 1'b1, 4'ha, 1'b1, mk({{12{8'hff}}, 32'h00ff5301}, 4'ha, 1'b1));
    drain();

    // Round trip: all 256 bytes forward, captured
    cap.delete();
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < L; k++) d[8*k +: 8] = 8'(16 * i + k);
      send(d, 1'b0, 4'(i), 1'b1, mk('0, 4'(i), 1'b0));
    end
    drain();
    chk("cap_count", cap.size() == 16, 128'(cap.size()), 128'd16);
    if (cap.size() == 16) begin
      chk("s_00", cap[0][7:0] == 8'h63, 128'(cap[0][7:0]), 128'h63);
      chk("s_01", cap[0][15:8] == 8'h7c, 128'(cap[0][15:8]), 128'h7c);
      chk("s_53", cap[5][31:24] == 8'hed, 128'(cap[5][31:24]), 128'hed);
      chk("s_ff", cap[15][127:120] == 8'h16, 128'(cap[15][127:120]), 128'h16);
      // Feed back inverse, interleaved with forward beats, back to back
      for (int i = 0; i < 16; i++) begin
        for (int k = 0; k < L; k++) d[8*k +: 8] = 8'(16 * i + k);
        send(cap[i], 1'b1, 4'(i), 1'b1, mk(d, 4'(i), 1'b1));
        chk("b2b_inv", s_ready, 128'(s_ready), 128'd1);
        send({16{8'h53}}, 1'b0, 4'(15 - i), 1'b1, mk({16{8'hed}}, 4'(15 - i), 1'b1));
      end
      drain();
    end

    // Backpressure: two accepts then stall
    for (int i = 0; i < 2; i++)
      send({16{fwd_a[i]}}, 1'b0, 4'(i), 1'b0, mk({16{fwd_b[i]}}, 4'(i), 1'b1));
    for (int c = 0; c < 3; c++) begin
      step(1'b1, {16{fwd_a[2]}}, 1'b0, 4'h2, 1'b0, 1'b0, mk({16{fwd_b[2]}}, 4'h2, 1'b1));
      chk("bp_ready_low", s_ready == 1'b0, 128'(s_ready), 128'd0);
      chk("bp_occ2", s_occ == 2'd2, 128'(s_occ), 128'd2);
    end
    // Release: beats 2..4 enter with no bubble, 5 outputs on consecutive cycles
    for (int i = 2; i < 5; i++) begin
      step(1'b1, {16{fwd_a[i % 4]}}, 1'b0, 4'(i), 1'b1, 1'b0, mk({16{fwd_b[i % 4]}}, 4'(i), 1'b1));
      chk("bp_accept", s_acc, 128'(s_acc), 128'd1);
      chk("bp_out_valid", s_ovalid, 128'(s_ovalid), 128'd1);
    end
    for (int i = 0; i < 2; i++) begin
      idle(1'b1);
      chk("bp_tail_valid", s_ovalid, 128'(s_ovalid), 128'd1);
    end
    idle(1'b1);
    chk("bp_done", s_ovalid == 1'b0, 128'(s_ovalid), 128'd0);

    // Flush with occupancy 2 while offering a beat
    for (int i = 0; i < 2; i++)
      send({16{fwd_a[i]}}, 1'b0, 4'(i), 1'b0, mk({16{fwd_b[i]}}, 4'(i), 1'b1));
    idle(1'b0);
    chk("fl_occ2", s_occ == 2'd2, 128'(s_occ), 128'd2);
    step(1'b1, {16{8'h53}}, 1'b0, 4'hf, 1'b1, 1'b1, mk({16{8'hed}}, 4'hf, 1'b1));
    chk("fl_in_ready", s_ready == 1'b1, 128'(s_ready), 128'd1);
    idle(1'b1);
    chk("fl_occ0", s_occ == 2'd0, 128'(s_occ), 128'd0);
    chk("fl_out_valid", s_ovalid == 1'b0, 128'(s_ovalid), 128'd0);
    for (int c = 0; c < 3; c++) idle(1'b1);

    // Asynchronous reset mid-stream with occupancy 2
    for (int i = 0; i < 2; i++)
      send({16{fwd_a[i]}}, 1'b0, 4'(i), 1'b0, mk({16{fwd_b[i]}}, 4'(i), 1'b1));
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid == 1'b0, 128'(out_valid), 128'd0);
    chk("arst_out_data", out_data == '0, out_data, '0);
    chk("arst_occ", occupancy == 2'd0, 128'(occupancy), 128'd0);
    chk("arst_in_ready", in_ready == 1'b1, 128'(in_ready), 128'd1);
    sbq.delete();
    @(posedge clk); #1; rst = 1'b0;

    // Random soak
    for (int c = 0; c < 600; c++) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 24) == 0);
      inv  = $urandom_range(0, 1);
      gen(inv, d, e);
      step(v, d, inv, 4'(c), ordy, fl, mk(e, 4'(c), 1'b1));
      chk("soak_occ", s_occ <= 2'd2 && (s_ready == (s_occ < 2'd2 || ordy)),
          128'(s_occ), 128'd2);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sub_bytes_pipe.md
# sub_bytes_pipe

Parametrised, pipelined SubBytes/InvSubBytes engine for the AES datapath. Substitutes LANES bytes per beat through the AES forward or inverse S-box, with the direction selected per beat. A valid/ready handshake with full backpressure lets it sit between the round-state register and ShiftRows in both the encryption and decryption round loops, and also serve the key-expansion SubWord path (LANES=4).

## Interface
Parameters:
- LANES, 16, bytes substituted per beat. Legal range 1..16.
- TAG_W, 4, width of the sideband tag carried alongside each beat. Legal range 1..16.

Ports (clock and reset are the already-decided single clock and asynchronous, active-high reset):
- clk  in  1  single clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all in-flight beats.
- in_valid  in  1  input beat present.
- in_ready  out  1  engine accepts a beat this cycle.
- in_data  in  8*LANES  byte k at bits [8k+7:8k].
- in_inv  in  1  0 = forward S-box, 1 = inverse S-box; sampled with the beat.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- out_data  out  8*LANES  substituted bytes, same lane order as in_data.
- out_tag  out  TAG_W  tag of the beat on out_data.
- occupancy  out  2  number of beats held (0..2).

## Operation
- A beat transfers on the input when in_valid && in_ready, and on the output when out_valid && out_ready.
- Two register stages:
  - S1 captures {in_data, in_inv, in_tag}.
  - S2 captures the per-lane S-box result of S1, with S1's tag.
- Per-lane function:
  - Forward is the FIPS-197 S-box: S(00)=63, S(01)=7c, S(53)=ed, S(ff)=16.
  - Inverse is its exact inverse: InvS(63)=00, InvS(16)=ff.
  - The lane function is purely combinational between S1 and S2; lanes are independent.
- Stage control:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no other combinational input-to-output paths).
  - S2 loads when s1_valid && s2_adv.
  - s2_valid clears when the output is accepted and S1 is empty.
- Data stability: out_data and out_tag hold while out_valid && !out_ready. S1 likewise holds its contents while stalled.
- occupancy = s1_valid + s2_valid.
- Flush:
  - Clears s1_valid and s2_valid on the next edge and has priority over every transfer.
  - A beat offered in the flush cycle is dropped; in_ready still follows the formula.
  - Data registers are not cleared by flush.
- Reset (asynchronous, mid-operation allowed):
  - s1_valid, s2_valid, out_data, out_tag, the S1 registers and occupancy all go to 0.
  - in_ready is therefore 1 during and after reset.
  - In-flight beats are lost.

## Timing
- Latency: a beat accepted at edge N is visible on out_valid/out_data after edge N+1 (two-register path). With out_ready held high, throughput is one beat per cycle.
- Stall: out_ready low with S2 full and S1 full drops in_ready to 0 in the same cycle. out_ready rising lets one beat move S1→S2 and one new beat enter S1 at that edge, so no bubble is inserted.
- Simultaneous input accept and output accept while full: legal; occupancy stays 2.
- Direction changes between consecutive beats: no penalty. in_inv travels with its beat.
- Combinational depth: one S-box lookup between S1 and S2. No lookup on the input or output ports.

## Structure
- Shared package aes_pkg:
  - the 256-entry forward and inverse S-box constant arrays;
  - typedef for a byte;
  - localparam for the FIPS-197 test bytes used by benches.
- One sub-module, sbox_lane: 8-bit combinational forward/inverse lookup selected by an inv input. It is instantiated LANES times with a generate loop.
- The top level holds only the pipeline registers, the handshake, flush and occupancy.

## Test plan
- **Reset.** Assert rst mid-stream with occupancy=2 → asynchronously out_valid=0, out_data=0, occupancy=0, in_ready=1.
- **Forward, LANES=4.**
  - Stimulus: in_data=32'h53ff0100, in_inv=0, tag=4'h5, out_ready=1.
  - Required response: out_data=32'hed167c63 with out_tag=5, exactly 2 edges after accept.
- **Inverse round trip, LANES=16.**
  - Stimulus: all 256 byte values in 16 beats forward, then the results fed back with in_inv=1.
  - Required response: the original bytes, with alternating-direction beats issued back-to-back.
- **Backpressure.**
  - Stimulus: stream of 5 beats with out_ready held 0.
  - Required response: in_ready drops after 2 accepts and occupancy=2, with out_data stable.
  - Then release out_ready: all 5 beats are delivered in order at 1 per cycle with no bubble.
- **Flush.**
  - Stimulus: flush with occupancy=2 while in_valid=1.
  - Required response: the next cycle has occupancy=0 and out_valid=0; the beat offered in the flush cycle never appears on the output.
- **Random soak.** Random in_valid/out_ready/in_inv/flush against a reference model → no loss, duplication or reordering outside flush windows.
